// File: rtl/snes_pad_reader.sv
// ---------------------------------------------------------------------------
// snes_pad_reader
//   Console-side SNES controller interface. Drives latch and shift clock to a
//   physical pad, shifts in its 16-bit active-low serial report and publishes
//   it as a registered, active-high button word with a one-cycle valid pulse.
//   A poll starts on a start pulse or, when POLL_CYCLES != 0, whenever the
//   free-running poll timer reaches its terminal count.
//
// Parameters
//   LATCH_CYCLES  clk cycles snes_latch is held high
//   HALF_CYCLES   clk cycles per snes_clk half-period (>= 3, see synchroniser)
//   POLL_CYCLES   auto-poll period in clk cycles, 0 disables auto-poll
//
// Ports
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   start       in   single-cycle poll request, honoured only when idle
//   snes_data   in   serial data from pad, active-low, asynchronous to clk
//   snes_latch  out  latch to pad, active-high
//   snes_clk    out  shift clock to pad, idles high
//   buttons     out  last completed report, 1 = pressed
//   valid       out  one-cycle pulse when buttons is updated
//   busy        out  high while a poll is in progress
// ---------------------------------------------------------------------------
module snes_pad_reader #(
  parameter int LATCH_CYCLES = 25,
  parameter int HALF_CYCLES  = 12,
  parameter int POLL_CYCLES  = 34667
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        snes_data,
  output logic        snes_latch,
  output logic        snes_clk,
  output logic [15:0] buttons,
  output logic        valid,
  output logic        busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LATCH    = 3'd1;
  localparam logic [2:0] S_CLK_LOW  = 3'd2;
  localparam logic [2:0] S_CLK_HIGH = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  // One phase counter serves both the latch pulse and the clock half-periods,
  // so it is sized for the longer of the two.
  localparam int PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CW        = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
  localparam int PW        = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

  logic [2:0]    state;
  logic [2:0]    next_state;
  logic [CW-1:0] phase_cnt;
  logic [3:0]    bit_idx;
  logic [15:0]   shift;
  logic          data_meta;
  logic          data_sync;
  logic [PW-1:0] poll_timer;
  logic          poll_hit;
  logic          phase_last;

  assign poll_hit = (POLL_CYCLES != 0) && (poll_timer == PW'(POLL_CYCLES - 1));

  assign phase_last =
      ((state == S_LATCH) && (phase_cnt == CW'(LATCH_CYCLES - 1))) ||
      (((state == S_CLK_LOW) || (state == S_CLK_HIGH)) &&
       (phase_cnt == CW'(HALF_CYCLES - 1)));

  // NOTE: every variable assigned in an always_comb gets a default first so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (start || poll_hit) next_state = S_LATCH;
      S_LATCH:    if (phase_last) next_state = S_CLK_LOW;
      S_CLK_LOW:  if (phase_last) next_state = S_CLK_HIGH;
      S_CLK_HIGH: if (phase_last) next_state = (bit_idx == 4'd15) ? S_DONE : S_CLK_LOW;
      S_DONE:     next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      phase_cnt  <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      data_meta  <= 1'b1;
      data_sync  <= 1'b1;
      poll_timer <= '0;
      snes_latch <= 1'b0;
      snes_clk   <= 1'b1;
      buttons    <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Pad data is asynchronous: two flops before anything looks at it.
      data_meta <= snes_data;
      data_sync <= data_meta;

      if (POLL_CYCLES == 0)  poll_timer <= '0;
      else if (poll_hit)     poll_timer <= '0;
      else                   poll_timer <= poll_timer + 1'b1;

      state <= next_state;

      // Counter restarts on every state change and rests at zero when idle,
      // so it never runs past the terminal count of the current phase.
      if ((state == S_IDLE) || (next_state != state)) phase_cnt <= '0;
      else                                            phase_cnt <= phase_cnt + 1'b1;

      if (state == S_LATCH)
        bit_idx <= '0;
      else if ((state == S_CLK_HIGH) && phase_last && (bit_idx != 4'd15))
        bit_idx <= bit_idx + 1'b1;

      // The pad changed its output on the previous snes_clk rise, at least
      // HALF_CYCLES ago, so the synchronised bit is settled here.
      if ((state == S_CLK_LOW) && (phase_cnt == '0))
        shift[bit_idx] <= data_sync;

      if (state == S_DONE) buttons <= ~shift;
      valid <= (state == S_DONE);

      // Pad-facing outputs are decoded from next_state so they change on the
      // same edge as the state and leave the block glitch-free.
      snes_latch <= (next_state == S_LATCH);
      snes_clk   <= (next_state != S_CLK_LOW);
      busy       <= (next_state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_snes_pad_reader.sv
// ---------------------------------------------------------------------------
// tb_snes_pad_reader
//   Bench for snes_pad_reader. A behavioural pad (parallel load on latch,
//   shift on snes_clk rise, active-low) feeds the main instance; a second
//   instance with auto-poll enabled runs from its own pad for the whole run.
//   Expected button words are the bitwise inverse of the pad's line levels.
// ---------------------------------------------------------------------------
module tb_snes_pad_reader;

  localparam int LATCH = 4;
  localparam int HALF  = 3;
  localparam int EXP_LAT = LATCH + 32 * HALF + 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        snes_data;
  logic        snes_latch;
  logic        snes_clk;
  logic [15:0] buttons;
  logic        valid;
  logic        busy;

  logic        reset_p_n;
  logic        p_data;
  logic        p_latch;
  logic        p_sclk;
  logic [15:0] p_buttons;
  logic        p_valid;
  logic        p_busy;

  logic [15:0] pad_word = 16'hFFFF;
  logic [15:0] pad_sr   = 16'hFFFF;
  logic [15:0] p_word   = 16'hFFFF;
  logic [15:0] p_sr     = 16'hFFFF;
  logic [1:0]  data_mode = 2'd0;  // 0 pad model, 1 line held high, 2 held low

  int total = 0;
  int bad   = 0;
  int fall_cnt  = 0;
  int latch_cyc = 0;
  int valid_cnt = 0;
  int cyc       = 0;
  int p_valid_times[$];

  always #5 clk = ~clk;

  snes_pad_reader #(.LATCH_CYCLES(LATCH), .HALF_CYCLES(HALF), .POLL_CYCLES(0)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .snes_data(snes_data),
    .snes_latch(snes_latch), .snes_clk(snes_clk), .buttons(buttons),
    .valid(valid), .busy(busy)
  );

  snes_pad_reader #(.LATCH_CYCLES(LATCH), .HALF_CYCLES(HALF), .POLL_CYCLES(200)) dut_poll (
    .clk(clk), .reset_n(reset_p_n), .start(1'b0), .snes_data(p_data),
    .snes_latch(p_latch), .snes_clk(p_sclk), .buttons(p_buttons),
    .valid(p_valid), .busy(p_busy)
  );

  // Pad models: load on latch, present next bit after each snes_clk rise.
  always @(posedge snes_latch or posedge snes_clk)
    if (snes_latch) pad_sr <= pad_word;
    else            pad_sr <= {1'b1, pad_sr[15:1]};

  always @(posedge p_latch or posedge p_sclk)
    if (p_latch) p_sr <= p_word;
    else         p_sr <= {1'b1, p_sr[15:1]};

  assign snes_data = (data_mode == 2'd1) ? 1'b1 : (data_mode == 2'd2) ? 1'b0 : pad_sr[0];
  assign p_data    = p_sr[0];

  always @(negedge snes_clk) fall_cnt++;

  always @(posedge clk) begin
    cyc++;
    if (snes_latch) latch_cyc++;
    if (valid) valid_cnt++;
    if (p_valid) p_valid_times.push_back(cyc);
  end

  // Runs one start-triggered poll; lat is the number of edges from the edge
  // that sampled start to the edge after which valid is seen (-1 on timeout).
  task automatic poll_once(output int lat);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 1000; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    // Let the counting block see the valid pulse.
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    reset_p_n = 1'b0;
    start     = 1'b0;
    #23;
    total++; if (snes_latch !== 1'b0) begin bad++; $display("FAIL reset_latch: got %b want 0", snes_latch); end
    total++; if (snes_clk !== 1'b1) begin bad++; $display("FAIL reset_sclk: got %b want 1", snes_clk); end
    total++; if (buttons !== 16'h0000) begin bad++; $display("FAIL reset_buttons: got %h want 0000", buttons); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk);
    reset_n   = 1'b1;
    reset_p_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, f0, l0, v0;
    pad_word = 16'hFEFE;
    data_mode = 2'd0;
    f0 = fall_cnt; l0 = latch_cyc; v0 = valid_cnt;
    poll_once(lat);
    total++; if (lat != EXP_LAT) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, EXP_LAT); end
    total++; if (buttons !== 16'h0101) begin bad++; $display("FAIL basic_buttons: got %h want 0101", buttons); end
    total++; if (fall_cnt - f0 != 16) begin bad++; $display("FAIL basic_falls: got %0d want 16", fall_cnt - f0); end
    total++; if (latch_cyc - l0 != LATCH) begin bad++; $display("FAIL basic_latch_len: got %0d want %0d", latch_cyc - l0, LATCH); end
    total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL basic_valid_count: got %0d want 1", valid_cnt - v0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_random();
    int lat;
    logic [15:0] w;
    for (int k = 0; k < 8; k++) begin
      w = 16'($urandom);
      pad_word = w;
      poll_once(lat);
      total++; if (lat != EXP_LAT) begin bad++; $display("FAIL random_latency[%0d]: got %0d want %0d", k, lat, EXP_LAT); end
      total++; if (buttons !== ~w) begin bad++; $display("FAIL random_buttons[%0d]: got %h want %h", k, buttons, ~w); end
    end
  endtask

  task automatic test_no_pad();
    int lat;
    data_mode = 2'd1;
    poll_once(lat);
    total++; if (buttons !== 16'h0000) begin bad++; $display("FAIL nopad_high: got %h want 0000", buttons); end
    data_mode = 2'd2;
    poll_once(lat);
    total++; if (buttons !== 16'hFFFF) begin bad++; $display("FAIL nopad_low: got %h want FFFF", buttons); end
    total++; if (lat != EXP_LAT) begin bad++; $display("FAIL nopad_latency: got %0d want %0d", lat, EXP_LAT); end
    data_mode = 2'd0;
  endtask

  task automatic test_start_while_busy();
    int f0, v0;
    logic [15:0] w;
    w = 16'($urandom);
    pad_word = w;
    f0 = fall_cnt; v0 = valid_cnt;
    start = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk);
      @(negedge clk);
      start = (busy === 1'b1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL busy_valid_count: got %0d want 1", valid_cnt - v0); end
    total++; if (fall_cnt - f0 != 16) begin bad++; $display("FAIL busy_falls: got %0d want 16", fall_cnt - f0); end
    total++; if (buttons !== ~w) begin bad++; $display("FAIL busy_buttons: got %h want %h", buttons, ~w); end
  endtask

  task automatic test_reset_mid_poll();
    int lat, f0, v0;
    bit reached;
    logic [15:0] w;
    pad_word = 16'h0F0F;
    poll_once(lat);
    total++; if (buttons !== 16'hF0F0) begin bad++; $display("FAIL midrst_pre_buttons: got %h want F0F0", buttons); end
    f0 = fall_cnt;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (fall_cnt - f0 >= 8) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++; if (!reached) begin bad++; $display("FAIL midrst_bit7_timeout: got %0d falls want 8", fall_cnt - f0); end
    v0 = valid_cnt;
    reset_n = 1'b0;
    #1;
    total++; if (snes_latch !== 1'b0) begin bad++; $display("FAIL midrst_latch: got %b want 0", snes_latch); end
    total++; if (snes_clk !== 1'b1) begin bad++; $display("FAIL midrst_sclk: got %b want 1", snes_clk); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    total++; if (buttons !== 16'h0000) begin bad++; $display("FAIL midrst_buttons: got %h want 0000", buttons); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (150) @(negedge clk);
    total++; if (valid_cnt != v0) begin bad++; $display("FAIL midrst_no_valid: got %0d pulses want 0", valid_cnt - v0); end
    total++; if (buttons !== 16'h0000) begin bad++; $display("FAIL midrst_hold: got %h want 0000", buttons); end
    w = 16'($urandom);
    pad_word = w;
    poll_once(lat);
    total++; if (buttons !== ~w) begin bad++; $display("FAIL midrst_next_buttons: got %h want %h", buttons, ~w); end
    total++; if (lat != EXP_LAT) begin bad++; $display("FAIL midrst_next_latency: got %0d want %0d", lat, EXP_LAT); end
  endtask

  task automatic test_auto_poll();
    for (int i = 0; i < 1200; i++) begin
      if (p_valid_times.size() >= 4) break;
      @(negedge clk);
    end
    total++; if (p_valid_times.size() < 4) begin bad++; $display("FAIL autopoll_count: got %0d want >=4", p_valid_times.size()); end
    for (int k = 1; k < 4; k++) begin
      if (k < p_valid_times.size()) begin
        total++;
        if (p_valid_times[k] - p_valid_times[k-1] != 200) begin
          bad++;
          $display("FAIL autopoll_period[%0d]: got %0d want 200", k, p_valid_times[k] - p_valid_times[k-1]);
        end
      end
    end
    total++; if (p_buttons !== ~p_word) begin bad++; $display("FAIL autopoll_buttons: got %h want %h", p_buttons, ~p_word); end
  endtask

  task automatic test_loopback_pattern();
    int lat;
    logic [7:0] d;
    d = 8'hA5;
    // Encoder-style pad: low 8 buttons from d, A/X/L/R released, ID bits high.
    pad_word = {8'hFF, ~d};
    poll_once(lat);
    total++; if (buttons[7:0] !== d) begin bad++; $display("FAIL loop_low: got %h want %h", buttons[7:0], d); end
    total++; if (buttons[15:12] !== 4'h0) begin bad++; $display("FAIL loop_id: got %h want 0", buttons[15:12]); end
  endtask

  initial begin
    p_word = 16'($urandom);
    test_reset();
    test_basic();
    test_random();
    test_no_pad();
    test_start_while_busy();
    test_reset_mid_poll();
    test_auto_poll();
    test_loopback_pattern();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
